// File: rtl/mul16_rr_scheduler.sv
// Round-robin front end for one shared external 16x16 multiplier; 2-stage pipe, response one edge after accept.
// Backpressure: a stalled response stage holds S1, which then drops req_ready until the response drains.
module mul16_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  logic            r_op_valid;
  logic [IDW-1:0]  r_op_id;
  logic [15:0]     r_mul_a;
  logic [15:0]     r_mul_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [31:0]     r_rsp_data;
  logic [IDW-1:0]  r_rr_ptr;

  logic            w_s2_free;
  logic            w_s1_free;
  logic            w_grant_vld;
  logic [IDW-1:0]  w_grant_id;
  logic            w_accept;
  logic [15:0]     w_sel_a;
  logic [15:0]     w_sel_b;
  logic [IDW-1:0]  w_rr_next;

  assign w_s2_free = !r_rsp_valid || rsp_ready;
  assign w_s1_free = !r_op_valid || w_s2_free;

  // Scan from the farthest offset down so the nearest valid requester to rr_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = IDW'(idx);
      end
    end
  end

  assign w_accept  = w_grant_vld && w_s1_free;
  assign w_rr_next = IDW'((int'(w_grant_id) + 1) % NREQ);

  always_comb begin
    req_ready = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_grant_id) begin
        w_sel_a = req_a[i*16 +: 16];
        w_sel_b = req_b[i*16 +: 16];
        req_ready[i] = w_accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_id    <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_rr_ptr   <= '0;
    end else if (w_s1_free) begin
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_op_id  <= w_grant_id;
        r_mul_a  <= w_sel_a;
        r_mul_b  <= w_sel_b;
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  // The product is sampled from the external multiplier while S1 still drives its inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_s2_free) begin
      r_rsp_valid <= r_op_valid;
      if (r_op_valid) begin
        r_rsp_id   <= r_op_id;
        r_rsp_data <= mul_p;
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_op_valid || r_rsp_valid;

endmodule
